// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: Galois step function, default tap masks, checker FSM states.
package lfsr_pkg;

  localparam int LFSR_MAX_W = 64;

  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    VERIFY,
    LOCKED
  } lfsr_state_e;

  // Predictor control: load reseeds from the input word, adv steps the held word.
  typedef struct packed {
    logic load;
    logic adv;
  } pred_ctl_t;

  // Right-shift Galois masks for a few common widths; unknown widths fall back to
  // a single top tap, which still gives a legal (if short) sequence.
  function automatic lfsr_word_t default_taps(input int w);
    case (w)
      4:       return 64'h0000_0000_0000_000C;
      8:       return 64'h0000_0000_0000_00B8;
      16:      return 64'h0000_0000_0000_B400;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_8020_0003;
      default: return lfsr_word_t'(1) << (w - 1);
    endcase
  endfunction

  // One Galois step; the caller zero-extends and truncates to its own width.
  function automatic lfsr_word_t galois_next(input lfsr_word_t s, input lfsr_word_t taps);
    return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
  endfunction

endpackage

// File: rtl/galois_lfsr_predict.sv
// Expected-word register: reseeds from the incoming word or free-runs one step per word.
module galois_lfsr_predict
  import lfsr_pkg::*;
#(
  parameter int                   BIT_WIDTH = 8,
  parameter logic [BIT_WIDTH-1:0] TAPS      = BIT_WIDTH'(default_taps(BIT_WIDTH))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  pred_ctl_t            ctl,
  input  logic [BIT_WIDTH-1:0] din,
  output logic [BIT_WIDTH-1:0] expected
);

  logic [BIT_WIDTH-1:0] src;

  // load has priority: a reseed predicts from the word just seen
  assign src = ctl.load ? din : expected;

  // Step the prediction whenever the FSM asks for a new expected word
  always_ff @(posedge clk) begin
    if (rst)
      expected <= '0;
    else if (ctl.load || ctl.adv)
      expected <= BIT_WIDTH'(galois_next(lfsr_word_t'(src), lfsr_word_t'(TAPS)));
  end

endmodule

// File: rtl/galois_lfsr_checker.sv
// Receive-side checker for a Galois LFSR word stream: syncs, locks, flywheels, counts errors.
module galois_lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int                   BIT_WIDTH  = 8,
  parameter logic [BIT_WIDTH-1:0] TAPS       = BIT_WIDTH'(default_taps(BIT_WIDTH)),
  parameter int                   LOCK_CNT   = 4,
  parameter int                   UNLOCK_CNT = 4,
  parameter int                   CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 clr_cnt,
  input  logic                 din_vld,
  input  logic [BIT_WIDTH-1:0] din_data,
  input  logic                 din_done,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 lock_lost,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [CNT_WIDTH-1:0] seq_cnt
);

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_CNT + 1);

  lfsr_state_e          state, state_nxt;
  logic [MW-1:0]        match_cnt;
  logic [BW-1:0]        bad_cnt;
  logic [BIT_WIDTH-1:0] expected;
  pred_ctl_t            pctl;

  logic hit, din_nz, match_last, bad_last;
  logic match_clr, match_inc, bad_clr, bad_inc;
  logic err_ev, lost_ev, word_ev, seq_ev;

  assign hit        = (din_data == expected);
  assign din_nz     = (din_data != '0);
  assign match_last = (match_cnt == MW'(LOCK_CNT - 1));
  assign bad_last   = (bad_cnt == BW'(UNLOCK_CNT - 1));

  galois_lfsr_predict #(
    .BIT_WIDTH (BIT_WIDTH),
    .TAPS      (TAPS)
  ) u_predict (
    .clk      (clk),
    .rst      (rst),
    .ctl      (pctl),
    .din      (din_data),
    .expected (expected)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: enable low always parks in IDLE; only valid words move SEED/VERIFY/LOCKED
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   state_nxt = SEED;
        SEED:   if (din_vld && din_nz) state_nxt = VERIFY;
        VERIFY: begin
          if (din_vld) begin
            if (hit) begin
              if (match_last) state_nxt = LOCKED;
            end else if (!din_nz) begin
              state_nxt = SEED;
            end
          end
        end
        LOCKED: if (din_vld && !hit && bad_last) state_nxt = SEED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Per-word controls and events; nothing happens without an armed, valid word
  always_comb begin
    pctl      = '0;
    match_clr = 1'b0;
    match_inc = 1'b0;
    bad_clr   = 1'b0;
    bad_inc   = 1'b0;
    err_ev    = 1'b0;
    lost_ev   = 1'b0;
    word_ev   = 1'b0;
    seq_ev    = 1'b0;
    if (enable && din_vld) begin
      case (state)
        SEED: begin
          if (din_nz) begin
            pctl.load = 1'b1;
            match_clr = 1'b1;
          end
        end
        VERIFY: begin
          if (hit) begin
            pctl.load = 1'b1;
            match_inc = 1'b1;
            bad_clr   = 1'b1;
          end else if (din_nz) begin
            pctl.load = 1'b1;
            match_clr = 1'b1;
          end
        end
        LOCKED: begin
          // flywheel: prediction advances from itself, never from a possibly corrupt input
          pctl.adv = 1'b1;
          word_ev  = 1'b1;
          seq_ev   = din_done;
          if (hit) begin
            bad_clr = 1'b1;
          end else begin
            err_ev = 1'b1;
            if (bad_last) begin
              lost_ev = 1'b1;
              bad_clr = 1'b1;
            end else begin
              bad_inc = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Consecutive-match and consecutive-mismatch run counters
  always_ff @(posedge clk) begin
    if (rst) begin
      match_cnt <= '0;
      bad_cnt   <= '0;
    end else begin
      if (match_clr)      match_cnt <= '0;
      else if (match_inc) match_cnt <= match_cnt + MW'(1);
      if (bad_clr)        bad_cnt   <= '0;
      else if (bad_inc)   bad_cnt   <= bad_cnt + BW'(1);
    end
  end

  // Registered status outputs, visible the cycle after the word that caused them
  always_ff @(posedge clk) begin
    if (rst) begin
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      locked    <= (state_nxt == LOCKED);
      err_pulse <= err_ev;
      lock_lost <= lost_ev;
    end
  end

  // Saturating statistics; a clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      err_cnt  <= '0;
      word_cnt <= '0;
      seq_cnt  <= '0;
    end else begin
      if (err_ev  && ~&err_cnt)  err_cnt  <= err_cnt  + CNT_WIDTH'(1);
      if (word_ev && ~&word_cnt) word_cnt <= word_cnt + CNT_WIDTH'(1);
      if (seq_ev  && ~&seq_cnt)  seq_cnt  <= seq_cnt  + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_galois_lfsr_checker.sv
// Self-checking bench for galois_lfsr_checker: directed table, corner sequences, random vs model.
module tb_galois_lfsr_checker;

  localparam int         LC = 4;
  localparam int         UC = 4;
  localparam logic [7:0] TP = 8'hB8;

  logic clk = 1'b0;
  logic rst = 1'b1, enable = 1'b0, clr_cnt = 1'b0;
  logic din_vld = 1'b0, din_done = 1'b0;
  logic [7:0] din_data = 8'h00;

  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_cnt, word_cnt, seq_cnt;
  logic        s_locked, s_err_pulse, s_lock_lost;
  logic [3:0]  s_err_cnt, s_word_cnt, s_seq_cnt;

  always #5 clk = ~clk;

  galois_lfsr_checker #(.BIT_WIDTH(8), .TAPS(TP), .LOCK_CNT(LC), .UNLOCK_CNT(UC), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clr_cnt(clr_cnt), .din_vld(din_vld),
    .din_data(din_data), .din_done(din_done), .locked(locked), .err_pulse(err_pulse),
    .lock_lost(lock_lost), .err_cnt(err_cnt), .word_cnt(word_cnt), .seq_cnt(seq_cnt));

  galois_lfsr_checker #(.BIT_WIDTH(8), .TAPS(TP), .LOCK_CNT(LC), .UNLOCK_CNT(UC), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .clr_cnt(clr_cnt), .din_vld(din_vld),
    .din_data(din_data), .din_done(din_done), .locked(s_locked), .err_pulse(s_err_pulse),
    .lock_lost(s_lock_lost), .err_cnt(s_err_cnt), .word_cnt(s_word_cnt), .seq_cnt(s_seq_cnt));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [7:0] nx(input logic [7:0] s);
    return (s >> 1) ^ (s[0] ? TP : 8'h00);
  endfunction

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  // Reference model: mode per word, counters kept as "events since last clear"
  localparam int M_IDLE = 0, M_SEED = 1, M_VER = 2, M_LOCK = 3;
  int         m_mode = M_IDLE, m_run = 0, m_bad = 0, m_err = 0, m_word = 0, m_seq = 0;
  logic [7:0] m_exp = 8'h00;
  bit         m_lk = 0, m_ep = 0, m_ll = 0;

  task automatic model_edge();
    m_ep = 0;
    m_ll = 0;
    if (rst) begin
      m_mode = M_IDLE; m_run = 0; m_bad = 0; m_exp = 8'h00;
      m_err = 0; m_word = 0; m_seq = 0;
    end else begin
      if (clr_cnt) begin m_err = 0; m_word = 0; m_seq = 0; end
      if (!enable) m_mode = M_IDLE;
      else if (m_mode == M_IDLE) m_mode = M_SEED;
      else if (din_vld) begin
        if (m_mode == M_SEED) begin
          if (din_data != 0) begin m_exp = nx(din_data); m_run = 0; m_mode = M_VER; end
        end else if (m_mode == M_VER) begin
          if (din_data == m_exp) begin
            m_run++;
            m_exp = nx(din_data);
            if (m_run == LC) begin m_mode = M_LOCK; m_bad = 0; end
          end else if (din_data != 0) begin
            m_exp = nx(din_data);
            m_run = 0;
          end else m_mode = M_SEED;
        end else begin
          if (!clr_cnt) begin m_word++; if (din_done) m_seq++; end
          if (din_data != m_exp) begin
            m_ep = 1;
            m_bad++;
            if (!clr_cnt) m_err++;
            if (m_bad == UC) begin m_ll = 1; m_mode = M_SEED; end
          end else m_bad = 0;
          m_exp = nx(m_exp);
        end
      end
    end
    m_lk = (m_mode == M_LOCK);
  endtask

  task automatic compare_all();
    chk("locked",      locked,      m_lk);
    chk("err_pulse",   err_pulse,   m_ep);
    chk("lock_lost",   lock_lost,   m_ll);
    chk("err_cnt",     err_cnt,     sat(m_err, 16));
    chk("word_cnt",    word_cnt,    sat(m_word, 16));
    chk("seq_cnt",     seq_cnt,     sat(m_seq, 16));
    chk("s_locked",    s_locked,    m_lk);
    chk("s_err_pulse", s_err_pulse, m_ep);
    chk("s_lock_lost", s_lock_lost, m_ll);
    chk("s_err_cnt",   s_err_cnt,   sat(m_err, 4));
    chk("s_word_cnt",  s_word_cnt,  sat(m_word, 4));
    chk("s_seq_cnt",   s_seq_cnt,   sat(m_seq, 4));
  endtask

  // One clock: drive inputs, let the model see the same edge, compare on the falling edge
  task automatic cyc(input logic v, input logic [7:0] d, input logic dn);
    din_vld  = v;
    din_data = d;
    din_done = dn;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    bit         en;
    bit         vld;
    logic [7:0] xm;
    bit         clr;
    bit         e_lk;
    bit         e_ep;
    bit         e_ll;
    int         e_err;
  } vec_t;

  vec_t       tbl[14];
  logic [7:0] gen;
  bit         held;
  int         burst;

  initial begin
    // en, vld, xor mask, clr -> locked, err_pulse, lock_lost, err_cnt
    tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0};  // IDLE -> SEED
    tbl[1]  = '{1, 1, 8'h00, 0, 0, 0, 0, 0};  // seed word
    tbl[2]  = '{1, 1, 8'h00, 0, 0, 0, 0, 0};  // match 1
    tbl[3]  = '{1, 1, 8'h00, 0, 0, 0, 0, 0};  // match 2
    tbl[4]  = '{1, 1, 8'h00, 0, 0, 0, 0, 0};  // match 3
    tbl[5]  = '{1, 1, 8'h00, 0, 1, 0, 0, 0};  // match 4 -> locked
    tbl[6]  = '{1, 0, 8'h00, 0, 1, 0, 0, 0};  // gap holds
    tbl[7]  = '{1, 1, 8'h01, 0, 1, 1, 0, 1};  // single bit error
    tbl[8]  = '{1, 1, 8'h00, 0, 1, 0, 0, 1};  // flywheel keeps prediction
    tbl[9]  = '{1, 1, 8'h80, 0, 1, 1, 0, 2};
    tbl[10] = '{1, 1, 8'h80, 0, 1, 1, 0, 3};
    tbl[11] = '{1, 1, 8'h80, 0, 1, 1, 0, 4};
    tbl[12] = '{1, 1, 8'h80, 0, 0, 1, 1, 5};  // 4th consecutive -> lock lost
    tbl[13] = '{1, 0, 8'h00, 1, 0, 0, 0, 0};  // clear counters

    // Reset values
    cyc(0, 8'h00, 0);
    cyc(0, 8'h00, 0);
    chk("rst_locked", locked, 0);
    chk("rst_errp",   err_pulse, 0);
    chk("rst_lost",   lock_lost, 0);
    chk("rst_err",    err_cnt, 0);
    chk("rst_word",   word_cnt, 0);
    chk("rst_seq",    seq_cnt, 0);

    // 300 contiguous words from seed 5A: word 0 seeds, 1..4 verify, 5..299 counted locked
    rst = 0; enable = 1;
    cyc(0, 8'h00, 0);
    gen = 8'h5A;
    for (int i = 0; i < 300; i++) begin
      cyc(1, gen, i == 299);
      gen = nx(gen);
      if (i == 3) chk("t1_not_yet", locked, 0);
      if (i == 4) chk("t1_lock_w4", locked, 1);
    end
    chk("t1_err",  err_cnt, 0);
    chk("t1_word", word_cnt, 295);
    chk("t1_seq",  seq_cnt, 1);

    // Random valid gaps while locked
    held = 1;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(1) != 0) begin
        cyc(0, 8'($urandom), 0);
        held &= locked;
      end
      cyc(1, gen, 0);
      gen = nx(gen);
      held &= locked;
    end
    chk("t4_held", held, 1);
    chk("t4_err",  err_cnt, 0);

    // Directed table from a fresh reset
    rst = 1; cyc(0, 8'h00, 0); rst = 0;
    gen = 8'h5A;
    foreach (tbl[i]) begin
      enable  = tbl[i].en;
      clr_cnt = tbl[i].clr;
      cyc(tbl[i].vld, gen ^ tbl[i].xm, 0);
      if (tbl[i].vld) gen = nx(gen);
      chk($sformatf("tbl%0d_locked", i), locked,    tbl[i].e_lk);
      chk($sformatf("tbl%0d_errp", i),   err_pulse, tbl[i].e_ep);
      chk($sformatf("tbl%0d_lost", i),   lock_lost, tbl[i].e_ll);
      chk($sformatf("tbl%0d_err", i),    err_cnt,   tbl[i].e_err);
    end
    clr_cnt = 0;

    // Relock after loss: one seed word plus four matches
    for (int i = 0; i < 5; i++) begin
      cyc(1, gen, 0);
      gen = nx(gen);
      if (i == 3) chk("t3_not_yet", locked, 0);
    end
    chk("t3_relock", locked, 1);

    // All-zero words never seed
    rst = 1; cyc(0, 8'h00, 0); rst = 0;
    cyc(0, 8'h00, 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'h00, 0);
    chk("t5_zero_unlocked", locked, 0);
    gen = 8'h01;
    for (int i = 0; i < 5; i++) begin cyc(1, gen, 0); gen = nx(gen); end
    chk("t5_lock", locked, 1);

    // Saturation on the 4-bit instance, then clear racing an error
    clr_cnt = 1; cyc(0, 8'h00, 0); clr_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1, gen ^ 8'h10, 0); gen = nx(gen);
      cyc(1, gen, 0);         gen = nx(gen);
      cyc(1, gen, 0);         gen = nx(gen);
    end
    chk("t6_s_err_sat", s_err_cnt, 4'hF);
    chk("t6_err",       err_cnt, 20);
    chk("t6_locked",    s_locked, 1);
    clr_cnt = 1; cyc(1, gen ^ 8'h10, 0); gen = nx(gen); clr_cnt = 0;
    chk("t6_clr_err",   err_cnt, 0);
    chk("t6_clr_s_err", s_err_cnt, 0);
    chk("t6_clr_pulse", err_pulse, 1);

    // Reset while locked with a mismatch run in progress
    cyc(1, gen, 0); gen = nx(gen);
    cyc(1, gen ^ 8'h04, 0); gen = nx(gen);
    cyc(1, gen ^ 8'h04, 0); gen = nx(gen);
    rst = 1; cyc(1, gen ^ 8'h04, 1); gen = nx(gen);
    chk("t7_locked", locked, 0);
    chk("t7_errp",   err_pulse, 0);
    chk("t7_lost",   lock_lost, 0);
    chk("t7_err",    err_cnt, 0);
    chk("t7_word",   word_cnt, 0);
    chk("t7_seq",    seq_cnt, 0);
    rst = 0;
    cyc(0, 8'h00, 0);
    chk("t7_idle_unlocked", locked, 0);

    // Random mix against the model: gaps, error bursts, enable drops, clears, resyncs, resets
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      logic       v;
      logic [7:0] xm;
      enable  = ($urandom_range(149) != 0);
      clr_cnt = ($urandom_range(199) == 0);
      rst     = ($urandom_range(999) == 0);
      if ($urandom_range(299) == 0) gen = 8'($urandom_range(255, 1));
      v  = ($urandom_range(2) != 0);
      xm = ($urandom_range(24) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      if ($urandom_range(199) == 0) burst = $urandom_range(6, 3);
      if (v && burst > 0) begin xm = 8'h55; burst--; end
      cyc(v, v ? (gen ^ xm) : 8'($urandom), v && ($urandom_range(49) == 0));
      if (v) gen = nx(gen);
    end
    rst = 0; clr_cnt = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
